// File: rtl/common.sv
// Shared fetch-path types: the queue entry record and the default queue depth.
package common;
  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int FETCH_ADDR_W      = 32;
  localparam int FETCH_DATA_W      = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two circular FIFO with synchronous flush; storage is not reset.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              wr_data,
  input  logic          pop,
  output T              rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  T              mem [DEPTH];

  // Flush wins over push/pop; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based request issue, in-order response capture,
// branch flush with drop accounting for reads already in flight.
module fetch_queue
  import common::*;
#(
  parameter int                    DEPTH      = FETCH_QUEUE_DEPTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rsp_data,
  input  logic                       branch_taken,
  input  logic [ADDR_WIDTH-1:0]      branch_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                starve_cycles
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_nxt;
  logic [CW-1:0]         drop_count;
  logic [CW:0]           credit_used;
  logic                  fire;
  logic                  rsp_keep;
  logic                  rsp_drop;
  logic                  pop;
  logic                  fifo_empty;
  fetch_entry_t          wr_entry;
  fetch_entry_t          rd_entry;

  // Queued plus in-flight entries may never exceed DEPTH, so a response always has room.
  assign credit_used   = {1'b0, occupancy} + {1'b0, outstanding};
  assign mem_req_valid = rst && !branch_taken && (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign fire          = mem_req_valid && mem_req_ready;

  assign rsp_keep = mem_rsp_valid && !branch_taken && (drop_count == '0);
  assign rsp_drop = mem_rsp_valid && !branch_taken && (drop_count != '0);
  assign pop      = out_valid && out_ready && !branch_taken;

  assign outstanding_nxt = outstanding + CW'(fire) - CW'(mem_rsp_valid);
  assign target_pc       = branch_target & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc      <= RESET_PC;
      rsp_pc        <= RESET_PC;
      outstanding   <= '0;
      drop_count    <= '0;
      starve_cycles <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_taken) begin
        fetch_pc   <= target_pc;
        rsp_pc     <= target_pc;
        drop_count <= outstanding_nxt;
      end else begin
        if (fire)     fetch_pc   <= fetch_pc + ADDR_WIDTH'(4);
        if (rsp_keep) rsp_pc     <= rsp_pc + ADDR_WIDTH'(4);
        if (rsp_drop) drop_count <= drop_count - CW'(1);
      end
      if (out_ready && !out_valid && (starve_cycles != '1))
        starve_cycles <= starve_cycles + 32'd1;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = FETCH_ADDR_W'(rsp_pc);
    wr_entry.instr = FETCH_DATA_W'(mem_rsp_data);
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_taken),
    .push    (rsp_keep),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .count   (occupancy),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = ADDR_WIDTH'(rd_entry.pc);
  assign out_instr = DATA_WIDTH'(rd_entry.instr);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed tables and sequences plus randomized traffic vs a queue model.
module tb_fetch_queue;
  import common::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  occupancy;
  logic [31:0] starve_cycles;

  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'h0;
  logic        w_branch = 1'b0;
  logic [31:0] w_target = 32'h0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_out_pc, w_out_instr;
  logic [2:0]  w_occupancy;
  logic [31:0] w_starve;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy), .starve_cycles(starve_cycles)
  );

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .branch_taken(w_branch), .branch_target(w_target),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
    .occupancy(w_occupancy), .starve_cycles(w_starve)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  pend_t pend[$];
  ent_t  mq[$];
  logic [31:0] m_fpc, m_rpc, m_starve;
  int m_outst, m_drop;

  function automatic logic [31:0] data_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_fpc = 32'h0; m_rpc = 32'h0; m_starve = 32'h0;
    m_outst = 0; m_drop = 0; last_due = 0;
  endtask

  function automatic logic exp_req_valid();
    return rst && !branch_taken && ((mq.size() + m_outst) < DEPTH);
  endfunction

  task automatic check_model();
    logic rv;
    rv = exp_req_valid();
    chk("req_valid", 32'(mem_req_valid), 32'(rv));
    if (rv) chk("req_addr", mem_req_addr, m_fpc);
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("starve", starve_cycles, m_starve);
  endtask

  // One clock: sample pre-edge, advance model and memory, drive this cycle's response.
  task automatic tick();
    logic s_rst, s_fire, s_pop, s_rsp, s_br, s_starve, d_fire;
    logic [31:0] s_data, s_tgt, d_addr;
    int due;
    s_rst    = rst;
    s_fire   = exp_req_valid() && mem_req_ready;
    s_pop    = (mq.size() > 0) && out_ready;
    s_rsp    = mem_rsp_valid;
    s_data   = mem_rsp_data;
    s_br     = branch_taken;
    s_tgt    = branch_target;
    s_starve = out_ready && (mq.size() == 0);
    d_fire   = mem_req_valid && mem_req_ready;
    d_addr   = mem_req_addr;
    @(posedge clk);
    cyc++;
    if (!s_rst) begin
      model_reset();
    end else begin
      if (s_starve && m_starve != 32'hFFFF_FFFF) m_starve++;
      if (s_br) begin
        mq.delete();
        m_fpc = {s_tgt[31:2], 2'b00};
        m_rpc = m_fpc;
        m_outst = m_outst - int'(s_rsp);
        m_drop = m_outst;
      end else begin
        if (s_pop) void'(mq.pop_front());
        if (s_fire) begin m_fpc += 32'd4; m_outst++; end
        if (s_rsp) begin
          m_outst--;
          if (m_drop > 0) m_drop--;
          else begin mq.push_back('{m_rpc, s_data}); m_rpc += 32'd4; end
        end
      end
      if (d_fire) begin
        due = cyc + $urandom_range(lat_min, lat_max) - 1;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{d_addr, due});
      end
    end
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    branch_taken = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        o_rdy;
    logic        rv;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] pc;
    int          occ;
  } vec_t;
  vec_t tbl[12];

  logic [31:0] wrap_exp[3];

  initial begin
    logic seen_req;
    logic seen_out;
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 0};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 0};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 2};
    tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 4};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 4};
    tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 4};
    tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3};
    tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 2};
    tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 2};
    tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 2};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    mem_req_ready = 1'b0; out_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_starve", starve_cycles, 32'h0);
    rst = 1'b1;

    // streaming, latency 1, plus the wrap-around instance
    mem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check_model();
      chk("stream_addr", mem_req_addr, 32'(4 * i));
      if (i >= 2) chk("stream_out_pc", out_pc, 32'(4 * (i - 2)));
      if (i < 3) chk("wrap_addr", w_req_addr, wrap_exp[i]);
      tick();
    end
    chk("stream_starve", starve_cycles, 32'd2);
    chk("wrap_out_valid", 32'(w_out_valid), 32'h0);

    // backpressure table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      out_ready = tbl[i].o_rdy;
      #1;
      chk("bp_req_valid", 32'(mem_req_valid), 32'(tbl[i].rv));
      chk("bp_req_addr", mem_req_addr, tbl[i].addr);
      chk("bp_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk("bp_out_pc", out_pc, tbl[i].pc);
        chk("bp_out_instr", out_instr, data_of(tbl[i].pc));
      end
      chk("bp_occupancy", 32'(occupancy), 32'(tbl[i].occ));
      tick();
    end

    // flush with three reads in flight
    do_reset();
    lat_min = 3; lat_max = 3; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin #1; check_model(); tick(); end
    branch_taken = 1'b1; branch_target = 32'h103;
    #1; check_model();
    tick();
    branch_taken = 1'b0;
    seen_req = 1'b0; seen_out = 1'b0;
    #1; chk("flush_next_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 20 && !seen_out; i++) begin
      if (i > 0) #1;
      check_model();
      if (!seen_req && mem_req_valid) begin chk("flush_first_req", mem_req_addr, 32'h100); seen_req = 1'b1; end
      if (out_valid) begin chk("flush_first_out_pc", out_pc, 32'h100); seen_out = 1'b1; end
      else tick();
    end
    if (!seen_out) chk("flush_timeout", 32'h0, 32'h1);

    // flush coinciding with pop and response
    do_reset();
    lat_min = 1; lat_max = 1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin #1; check_model(); tick(); end
    branch_taken = 1'b1; branch_target = 32'h200;
    #1; check_model();
    tick();
    branch_taken = 1'b0;
    #1;
    chk("simul_out_valid", 32'(out_valid), 32'h0);
    chk("simul_occupancy", 32'(occupancy), 32'h0);
    seen_out = 1'b0;
    for (int i = 0; i < 20 && !seen_out; i++) begin
      if (i > 0) #1;
      check_model();
      if (out_valid) begin chk("simul_first_out_pc", out_pc, 32'h200); seen_out = 1'b1; end
      else tick();
    end
    if (!seen_out) chk("simul_timeout", 32'h0, 32'h1);

    // mid-run reset with a full queue
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin #1; check_model(); tick(); end
    #1;
    chk("full_occupancy", 32'(occupancy), 32'd4);
    rst = 1'b0;
    #1;
    chk("midrst_occupancy", 32'(occupancy), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_first_valid", 32'(mem_req_valid), 32'h1);
    chk("midrst_first_addr", mem_req_addr, 32'h0);

    // randomized traffic
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 2000; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      #1;
      check_model();
      tick();
    end
    branch_taken = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
